// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults, 3x3 tap indices and FSM state encoding for the Sobel window generator
package sobel_pkg;
  localparam int PIX_W_DEF  = 4;
  localparam int ADDR_W_DEF = 10;
  localparam int TAP_TL = 0;
  localparam int TAP_T  = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_L  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_R  = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_B  = 7;
  localparam int TAP_BR = 8;
  typedef enum logic [2:0] {IDLE, STREAM, EOL, FLUSH, DONE} state_e;
endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image row of pixels, combinational read of the old value and write of the new one at the same column
module sobel_line_buf #(
  parameter int IMG_W = 32,
  parameter int PIX_W = 4,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);
  logic [PIX_W-1:0] mem_q [IMG_W];
  assign dout = mem_q[addr];
  // row store; contents survive reset since every frame rewrites them before use
  always_ff @(posedge clk)
    if (we) mem_q[addr] <= din;
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixel stream to 3x3 windows with border padding; define SOBEL_WIN_REPLICATE_EN for edge replication instead of zeros
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [9*PIX_W-1:0] win_out,
  output logic [ADDR_W-1:0]  win_addr,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               frame_done
);
  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = $clog2(IMG_W);
`ifdef SOBEL_WIN_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  typedef logic [2:0][PIX_W-1:0] col_t;
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, win_addr_q, win_addr_d;
  logic win_valid_q, win_valid_d;
  logic [9*PIX_W-1:0] win_out_q, win_out_d, win;
  col_t [2:0] sr_q, sr_d;
  col_t nc, l, m, rc;
  logic [PIX_W-1:0] lb1_rd, lb2_rd, bot;
  logic can_load, accept, row_end, flush_pre, flush_mid, flush_end, eol_go;
  logic emit, shift, edge_step, pad_l, pad_t, last_taken;
  sobel_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk(clk), .we(accept), .addr(col_q[AW-1:0]), .din(pix_in), .dout(lb1_rd)
  );
  sobel_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb2 (
    .clk(clk), .we(accept), .addr(col_q[AW-1:0]), .din(lb1_rd), .dout(lb2_rd)
  );
  // control strobes: handshakes, per-state work steps and the final-consumption detect
  always_comb begin
    can_load   = !win_valid_q || win_ready;
    pix_ready  = state_q == STREAM && can_load;
    frame_done = state_q == DONE;
    accept     = pix_valid && pix_ready;
    row_end    = accept && col_q == CW'(IMG_W - 1);
    flush_pre  = state_q == FLUSH && col_q == '0;
    flush_mid  = state_q == FLUSH && col_q != '0 && col_q < CW'(IMG_W) && can_load;
    flush_end  = state_q == FLUSH && col_q == CW'(IMG_W) && can_load;
    eol_go     = state_q == EOL && can_load;
    emit       = (accept && row_q != '0 && col_q != '0) || flush_mid || flush_end || eol_go;
    shift      = accept || flush_pre || flush_mid;
    last_taken = state_q == FLUSH && win_valid_q && win_ready && win_addr_q == ADDR_W'(IMG_W * IMG_H - 1);
  end
  // next state: EOL emits the right-edge centre of each row, FLUSH drains the bottom row
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? STREAM : IDLE;
      STREAM:  state_d = row_end && row_q != '0 ? EOL : STREAM;
      EOL:     state_d = !can_load ? EOL : row_q == RW'(IMG_H - 1) ? FLUSH : STREAM;
      FLUSH:   state_d = last_taken ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  // window assembly from the two newest shifted columns plus the incoming column, then padding and counters
  always_comb begin
    bot       = state_q == FLUSH ? (REP ? lb1_rd : '0) : pix_in;
    nc        = {bot, lb1_rd, lb2_rd};
    edge_step = state_q == EOL || (state_q == FLUSH && col_q == CW'(IMG_W));
    pad_l     = !edge_step && col_q == CW'(1);
    pad_t     = state_q != FLUSH && row_q == RW'(1);
    m         = sr_q[2];
    l         = pad_l ? (REP ? m : '0) : sr_q[1];
    rc        = edge_step ? (REP ? m : '0) : nc;
    l[0]      = pad_t ? (REP ? l[1] : '0) : l[0];
    m[0]      = pad_t ? (REP ? m[1] : '0) : m[0];
    rc[0]     = pad_t ? (REP ? rc[1] : '0) : rc[0];
    win       = {rc[2], m[2], l[2], rc[1], m[1], l[1], rc[0], m[0], l[0]};
    sr_d      = shift ? {nc, sr_q[2], sr_q[1]} : sr_q;
    row_d     = state_q == IDLE ? '0 : (row_end && row_q == '0) || (eol_go && row_q != RW'(IMG_H - 1)) ? row_q + 1'b1 : row_q;
    col_d     = state_q == IDLE ? '0 : row_end ? '0 : (accept || flush_pre || flush_mid || flush_end) ? col_q + 1'b1 : col_q;
    cnt_d     = state_q == IDLE ? '0 : emit ? cnt_q + 1'b1 : cnt_q;
    win_valid_d = emit || (win_valid_q && !win_ready);
    win_out_d   = emit ? win : win_out_q;
    win_addr_d  = emit ? cnt_q : win_addr_q;
  end
  // control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      win_valid_q <= 1'b0;
      win_out_q   <= '0;
      win_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      win_valid_q <= win_valid_d;
      win_out_q   <= win_out_d;
      win_addr_q  <= win_addr_d;
    end
  end
  // column shift registers; stale contents are always masked by padding before use
  always_ff @(posedge clk) sr_q <= sr_d;
  assign win_out   = win_out_q;
  assign win_addr  = win_addr_q;
  assign win_valid = win_valid_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: randomized frames checked against an image-indexing window model
module tb_sobel_window_gen;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int M_PAT = 0;
  localparam int M_BP = 1;
  localparam int M_GAP = 2;
  localparam int M_RAND = 3;
  localparam logic [35:0] C5 = {4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2, 4'd1, 4'd0};
`ifdef SOBEL_WIN_REPLICATE_EN
  localparam logic [35:0] C0  = {4'd5, 4'd4, 4'd4, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
  localparam logic [35:0] C15 = {4'd15, 4'd15, 4'd14, 4'd15, 4'd15, 4'd14, 4'd11, 4'd11, 4'd10};
`else
  localparam logic [35:0] C0  = {4'd5, 4'd4, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  localparam logic [35:0] C15 = {4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd14, 4'd0, 4'd11, 4'd10};
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic pix_valid = 1'b0;
  logic win_ready = 1'b0;
  logic [3:0] pix_in = '0;
  logic pix_ready, win_valid, frame_done;
  logic [35:0] win_out;
  logic [3:0] win_addr;
  int checks = 0;
  int failures = 0;
  int img [N];
  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_out(win_out), .win_addr(win_addr),
    .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] model_win(input int a);
    int r, c, rr, cc;
    logic [35:0] w;
    w = '0;
    r = a / W;
    c = a % W;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
`ifdef SOBEL_WIN_REPLICATE_EN
      rr = rr < 0 ? 0 : rr > H - 1 ? H - 1 : rr;
      cc = cc < 0 ? 0 : cc > W - 1 ? W - 1 : cc;
`endif
      if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[k*4 +: 4] = 4'(img[rr * W + cc]);
    end
    return w;
  endfunction
  task automatic run_frame(input int mode, input int npix);
    int pix_idx, exp_idx, hold, cyc;
    bit bp_done, prev_stall, seen_done;
    logic [35:0] prev_out;
    logic [3:0] prev_addr;
    pix_idx = 0; exp_idx = 0; hold = 0; cyc = 0;
    bp_done = 0; prev_stall = 0; seen_done = 0;
    prev_out = '0; prev_addr = '0;
    for (int i = 0; i < N; i++) img[i] = mode == M_RAND ? int'($urandom_range(0, 15)) : i % 16;
    while (!seen_done && cyc < 2000 && !(npix < N && pix_idx >= npix)) begin
      @(negedge clk);
      en = cyc == 0 ? 1'b1 : (mode == M_RAND && exp_idx < N) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode == M_BP) begin
        if (!bp_done && win_valid && win_addr == 4'd6) begin
          hold = 5;
          bp_done = 1;
        end
        win_ready = hold == 0;
        if (hold > 0) hold--;
      end else begin
        win_ready = mode == M_PAT ? 1'b1 : $urandom_range(0, 3) != 0;
      end
      pix_valid = (mode == M_PAT || mode == M_BP) ? pix_idx < N : 1'($urandom_range(0, 1));
      pix_in = pix_idx < N ? 4'(img[pix_idx]) : 4'($urandom_range(0, 15));
      #1;
      if (prev_stall) begin
        chk("hold_valid", win_valid, 1'b1);
        chk("hold_data", win_out, prev_out);
        chk("hold_addr", win_addr, prev_addr);
      end
      if (win_valid && !win_ready) chk("stall_pix_ready", pix_ready, 1'b0);
      if (pix_idx >= N) chk("flush_pix_ready", pix_ready, 1'b0);
      if (win_valid && win_ready) begin
        chk("win_addr", win_addr, 36'(exp_idx));
        chk("win_out", win_out, model_win(exp_idx));
        if (mode != M_RAND && (exp_idx == 0 || exp_idx == 5 || exp_idx == 15))
          chk("win_const", win_out, exp_idx == 0 ? C0 : exp_idx == 5 ? C5 : C15);
        exp_idx++;
      end
      if (pix_valid && pix_ready) pix_idx++;
      if (frame_done) begin
        chk("done_after_last", 36'(exp_idx), 36'(N));
        seen_done = 1;
      end
      prev_stall = win_valid && !win_ready;
      prev_out = win_out;
      prev_addr = win_addr;
      cyc++;
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    pix_valid = 1'b0;
    if (npix >= N) begin
      chk("frame_done_seen", seen_done, 1'b1);
      chk("win_count", 36'(exp_idx), 36'(N));
      if (mode == M_BP) chk("bp_applied", bp_done, 1'b1);
      @(negedge clk);
      #1;
      chk("done_pulse_width", frame_done, 1'b0);
      chk("idle_win_valid", win_valid, 1'b0);
      chk("idle_pix_ready", pix_ready, 1'b0);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_win_out", win_out, 36'd0);
    chk("rst_win_addr", win_addr, 36'd0);
    rst = 1'b1;
    run_frame(M_PAT, N);
    run_frame(M_BP, N);
    run_frame(M_GAP, N);
    run_frame(M_RAND, N);
    run_frame(M_RAND, N);
    run_frame(M_PAT, 7);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_win_valid", win_valid, 1'b0);
    chk("midrst_pix_ready", pix_ready, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    rst = 1'b1;
    pix_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_idle", pix_ready, 1'b0);
    pix_valid = 1'b0;
    run_frame(M_PAT, N);
    run_frame(M_GAP, N);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
